johnson_ring_step: RTL and testbench

- Registered next-state stage for a 4-bit (parameterizable) shift counter. It can run as a ring counter or as a Johnson (twisted-ring) counter.
- The current state is supplied externally on `state_in`. The registered next state appears on `state_out`.
- The enclosing logic closes the loop by feeding `state_out` back to `state_in` and seeds the initial pattern, e.g. 4'b1000.
- The block also flags state codes that are illegal for the selected mode.

---
 rtl/shift_counter_pkg.sv | 46 ++++
 rtl/shift_next_logic.sv | 45 ++++
 rtl/johnson_ring_step.sv | 51 +++++
 tb/tb_johnson_ring_step.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/shift_counter_pkg.sv
// -----------------------------------------------------------------------------
// shift_counter_pkg
// Shared definitions for the ring / Johnson shift-counter step logic.
//   MODE_RING / MODE_JOHNSON : encodings of the 1-bit mode select.
//   MAX_WIDTH                : widest state the helper functions accept.
//   onehot(code)             : 1 when exactly one bit of code is set.
//   johnson_legal(width,code): 1 when code[width-1:0] is one of the 2*width
//                              Johnson codes (a single run of ones anchored
//                              at either end, including all-zero and all-one).
// Callers zero-extend their state to MAX_WIDTH before calling the helpers.
// -----------------------------------------------------------------------------
package shift_counter_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;

    localparam int MAX_WIDTH = 32;

    // Exactly one bit set. Bits above the caller's width are zero, so they
    // never contribute to the count.
    function automatic logic onehot(input logic [MAX_WIDTH-1:0] code);
        int ones;
        ones = 0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            ones = ones + int'(code[i]);
        end
        return (ones == 1);
    endfunction

    // A Johnson code has at most one boundary between adjacent bits where the
    // value flips: zero flips means all-zero or all-one, one flip means a run
    // of ones touching either the MSB or the LSB. Two or more flips means a
    // floating run or a broken pattern.
    function automatic logic johnson_legal(input int width,
                                           input logic [MAX_WIDTH-1:0] code);
        int flips;
        flips = 0;
        for (int i = 0; i < MAX_WIDTH - 1; i++) begin
            if (i < width - 1) begin
                flips = flips + int'(code[i] ^ code[i+1]);
            end
        end
        return (flips <= 1);
    endfunction

endpackage

// File: rtl/shift_next_logic.sv
// -----------------------------------------------------------------------------
// shift_next_logic
// Purely combinational next-state and legality check for a shift counter.
// Ports:
//   mode         : 0 = ring, 1 = Johnson.
//   state_in     : current state {D..A}, MSB = D.
//   state_next   : state shifted one place toward the LSB; the vacated MSB
//                  takes A (ring) or ~A (Johnson).
//   illegal_next : state_in is not a legal code for mode.
// -----------------------------------------------------------------------------
module shift_next_logic
    import shift_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             mode,
    input  logic [WIDTH-1:0] state_in,
    output logic [WIDTH-1:0] state_next,
    output logic             illegal_next
);

    logic [MAX_WIDTH-1:0] state_ext;
    logic                 feedback_bit;

    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path, here by assigning defaults first, so no latch is inferred.
        state_ext    = '0;
        feedback_bit = state_in[0];
        illegal_next = 1'b0;

        state_ext[WIDTH-1:0] = state_in;

        if (mode == MODE_JOHNSON) begin
            feedback_bit = ~state_in[0];
            illegal_next = ~johnson_legal(WIDTH, state_ext);
        end else begin
            illegal_next = ~onehot(state_ext);
        end

        // Illegal codes are shifted just like legal ones; nothing self-corrects.
        state_next = {feedback_bit, state_in[WIDTH-1:1]};
    end

endmodule

// File: rtl/johnson_ring_step.sv
// -----------------------------------------------------------------------------
// johnson_ring_step
// Registered next-state stage of a ring / Johnson shift counter. The loop is
// closed outside this block by feeding state_out back into state_in.
// Ports:
//   clk       : rising-edge clock.
//   rst       : asynchronous active-high reset; clears both outputs at once.
//   mode      : 0 = ring, 1 = Johnson; applies at the very next edge.
//   state_in  : current state, sampled only at the rising edge.
//   state_out : registered next state (one clock of latency).
//   illegal   : registered flag, state_in was not legal for mode at the
//               last capture edge. Informational only.
// -----------------------------------------------------------------------------
module johnson_ring_step
    import shift_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [WIDTH-1:0] state_in,
    output logic [WIDTH-1:0] state_out,
    output logic             illegal
);

    logic [WIDTH-1:0] state_next;
    logic             illegal_next;

    shift_next_logic #(
        .WIDTH (WIDTH)
    ) u_next (
        .mode         (mode),
        .state_in     (state_in),
        .state_next   (state_next),
        .illegal_next (illegal_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_out <= '0;
            illegal   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_out <= state_next;
            illegal   <= illegal_next;
        end
    end

endmodule

// File: tb/tb_johnson_ring_step.sv
// -----------------------------------------------------------------------------
// tb_johnson_ring_step
// Directed bench for johnson_ring_step (WIDTH = 4): a table of single-step
// vectors followed by hand-written multi-cycle sequences (async reset, closed
// ring and Johnson loops, mode switch, sampling, long feedback run).
// Clock period is 1000 time units; outputs are checked 1 unit after the edge.
// -----------------------------------------------------------------------------
module tb_johnson_ring_step;

    localparam int W = 4;

    typedef struct {
        string      name;
        logic       mode;
        logic [W-1:0] state_in;
        logic [W-1:0] exp_out;
        logic       exp_ill;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         mode;
    logic [W-1:0] state_in;
    logic [W-1:0] state_out;
    logic         illegal;

    int pass_cnt = 0;
    int total_cnt = 0;

    vec_t         vecs[14];
    logic [W-1:0] ring_seq[4];
    logic [W-1:0] johnson_seq[8];

    johnson_ring_step #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .state_in  (state_in),
        .state_out (state_out),
        .illegal   (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #500 clk = ~clk;
    end

    task automatic check(input string name, input logic [W-1:0] exp_out,
                         input logic exp_ill);
        total_cnt++;
        if (state_out === exp_out && illegal === exp_ill) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: state_out=%b illegal=%b, expected state_out=%b illegal=%b",
                     name, state_out, illegal, exp_out, exp_ill);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Single-step vectors, expected values worked by hand.
        vecs[0]  = '{"ring 1000",    1'b0, 4'b1000, 4'b0100, 1'b0};
        vecs[1]  = '{"ring 0001",    1'b0, 4'b0001, 4'b1000, 1'b0};
        vecs[2]  = '{"ring 0010",    1'b0, 4'b0010, 4'b0001, 1'b0};
        vecs[3]  = '{"ring 0110",    1'b0, 4'b0110, 4'b0011, 1'b1};
        vecs[4]  = '{"ring 0000",    1'b0, 4'b0000, 4'b0000, 1'b1};
        vecs[5]  = '{"ring 1111",    1'b0, 4'b1111, 4'b1111, 1'b1};
        vecs[6]  = '{"johnson 0000", 1'b1, 4'b0000, 4'b1000, 1'b0};
        vecs[7]  = '{"johnson 1111", 1'b1, 4'b1111, 4'b0111, 1'b0};
        vecs[8]  = '{"johnson 1010", 1'b1, 4'b1010, 4'b1101, 1'b1};
        vecs[9]  = '{"johnson 0100", 1'b1, 4'b0100, 4'b1010, 1'b1};
        vecs[10] = '{"johnson 0011", 1'b1, 4'b0011, 4'b0001, 1'b0};
        vecs[11] = '{"johnson 1110", 1'b1, 4'b1110, 4'b1111, 1'b0};
        vecs[12] = '{"johnson 0001", 1'b1, 4'b0001, 4'b0000, 1'b0};
        vecs[13] = '{"johnson 0110", 1'b1, 4'b0110, 4'b1011, 1'b1};

        ring_seq    = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        johnson_seq = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                        4'b1111, 4'b0111, 4'b0011, 4'b0001};

        rst      = 1'b1;
        mode     = 1'b0;
        state_in = 4'b0000;
        #1;
        check("reset state", 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven single steps.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            mode     = vecs[i].mode;
            state_in = vecs[i].state_in;
            edge_sample();
            check(vecs[i].name, vecs[i].exp_out, vecs[i].exp_ill);
        end

        // Async reset between edges: preload 1010 (illegal=1), then pulse rst.
        @(negedge clk);
        mode     = 1'b0;
        state_in = 4'b0101;
        edge_sample();
        check("preload 1010", 4'b1010, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async reset mid-cycle", 4'b0000, 1'b0);
        rst = 1'b0;

        // Closed ring loop from seed 1000.
        @(negedge clk);
        mode     = 1'b0;
        state_in = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            edge_sample();
            check($sformatf("ring loop step %0d", k), ring_seq[(k + 1) % 4], 1'b0);
            state_in = state_out;
        end

        // Closed Johnson loop from seed 0000, two full periods.
        @(negedge clk);
        mode     = 1'b1;
        state_in = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            edge_sample();
            check($sformatf("johnson loop step %0d", k), johnson_seq[(k + 1) % 8], 1'b0);
            state_in = state_out;
        end

        // Mode switch: ring reaches 0001, then Johnson applies at the next edge.
        @(negedge clk);
        mode     = 1'b0;
        state_in = 4'b0010;
        edge_sample();
        check("switch ring to 0001", 4'b0001, 1'b0);
        state_in = state_out;
        mode     = 1'b1;
        edge_sample();
        check("switch johnson from 0001", 4'b0000, 1'b0);
        state_in = state_out;
        edge_sample();
        check("switch johnson next", 4'b1000, 1'b0);

        // Sampling: a mid-cycle input change must not reach the output
        // until the following edge.
        @(negedge clk);
        mode     = 1'b1;
        state_in = 4'b1100;
        edge_sample();
        check("sample edge value", 4'b1110, 1'b0);
        #499 state_in = 4'b0011;
        #400;
        check("sample hold mid-cycle", 4'b1110, 1'b0);
        @(posedge clk);
        #5;
        check("sample after next edge", 4'b0001, 1'b0);

        // Long Johnson feedback run, no drift over 60 edges.
        @(negedge clk);
        mode     = 1'b1;
        state_in = 4'b0000;
        for (int k = 0; k < 60; k++) begin
            edge_sample();
            check($sformatf("long run step %0d", k), johnson_seq[(k + 1) % 8], 1'b0);
            state_in = state_out;
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
